// File: rtl/axi_pkg.sv
// Shared AXI4 encodings used by the read subordinate and its masters.
package axi_pkg;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } AxiResp_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10,
    AXI_BURST_RSVD  = 2'b11
  } AxiBurst_t;

  typedef logic [2:0] AxiSize_t;

endpackage

// File: rtl/axi_rd_subordinate_if.sv
// AXI4 read address / read data channel bundle (AR and R).
interface axi_rd_subordinate_if #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_subordinate.sv
// AXI4 read subordinate: one burst at a time served from a 1-cycle-latency RAM
// port, with a 2-entry credit-managed output FIFO.
module axi_rd_subordinate
  import axi_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MEM_DEPTH = 1024,
  localparam int unsigned MEM_AW   = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_rd_subordinate_if.slave  axi,
  output logic                 mem_rd_en,
  output logic [MEM_AW-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_rdata
);

  localparam int unsigned BYTE_LG = $clog2(DATA_W / 8);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(MEM_DEPTH * (DATA_W / 8));

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    AxiResp_t          resp;
    logic              last;
  } r_beat_t;

  state_t            state_q, state_d;
  logic              arready_q, arready_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wrap_mask_q, wrap_mask_d;
  logic [2:0]        size_q, size_d;
  AxiBurst_t         burst_q, burst_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  AxiResp_t          resp_q, resp_d;
  logic              ret_q, ret_d;
  logic              ret_last_q, ret_last_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  r_beat_t           head_q, head_d;
  r_beat_t           tail_q, tail_d;
  logic              rvalid_q, rvalid_d;

  logic              pop;
  logic              issue;
  logic [2:0]        occ;
  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] next_addr;
  r_beat_t           new_beat;
  logic              dec_err;
  logic              slv_err;
  AxiBurst_t         ar_burst;

  // Credit uses occupancy after this cycle's pop so rready=1 sustains 1 beat/cycle.
  always_comb begin
    pop   = rvalid_q && axi.rready;
    occ   = 3'(fifo_cnt_q) + 3'(ret_q) - 3'(pop);
    issue = (state_q == ST_ISSUE) && (occ < 3'd2);
  end

  assign mem_rd_en = issue && (resp_q == AXI_RESP_OKAY);
  assign mem_addr  = addr_q[BYTE_LG +: MEM_AW];

  // Beat-to-beat address step.
  always_comb begin
    bytes = ADDR_W'(1) << size_q;
    unique case (burst_q)
      AXI_BURST_FIXED: next_addr = addr_q;
      AXI_BURST_WRAP:  next_addr = (addr_q & ~wrap_mask_q) | ((addr_q + bytes) & wrap_mask_q);
      default:         next_addr = (addr_q & ~(bytes - ADDR_W'(1))) + bytes;
    endcase
  end

  // AR acceptance checks.
  always_comb begin
    ar_burst = (axi.arburst == 2'b11) ? AXI_BURST_INCR : AxiBurst_t'(axi.arburst);
    dec_err  = {1'b0, axi.araddr} >= MEM_BYTES;
    slv_err  = (axi.arsize > 3'(BYTE_LG)) ||
               ((ar_burst == AXI_BURST_WRAP) && !(axi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
  end

  always_comb begin
    state_d     = state_q;
    arready_d   = arready_q;
    id_d        = id_q;
    addr_d      = addr_q;
    wrap_mask_d = wrap_mask_q;
    size_d      = size_q;
    burst_d     = burst_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    resp_d      = resp_q;
    ret_d       = issue;
    ret_last_d  = issue && (cnt_q == len_q);
    fifo_cnt_d  = fifo_cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;

    new_beat.data = (resp_q == AXI_RESP_OKAY) ? mem_rdata : '0;
    new_beat.resp = resp_q;
    new_beat.last = ret_last_q;

    // Output FIFO: head entry drives the R payload directly.
    case ({ret_q, pop})
      2'b10: begin
        if (fifo_cnt_q == 2'd0) head_d = new_beat;
        else                    tail_d = new_beat;
        fifo_cnt_d = fifo_cnt_q + 2'd1;
      end
      2'b01: begin
        head_d     = tail_q;
        fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
      2'b11: begin
        if (fifo_cnt_q == 2'd1) begin
          head_d = new_beat;
        end else begin
          head_d = tail_q;
          tail_d = new_beat;
        end
      end
      default: ;
    endcase
    rvalid_d = (fifo_cnt_d != 2'd0);

    unique case (state_q)
      ST_IDLE: begin
        if (axi.arvalid && arready_q) begin
          id_d        = axi.arid;
          addr_d      = axi.araddr;
          size_d      = axi.arsize;
          burst_d     = ar_burst;
          len_d       = axi.arlen;
          cnt_d       = 8'd0;
          wrap_mask_d = ((ADDR_W'(axi.arlen) + ADDR_W'(1)) << axi.arsize) - ADDR_W'(1);
          resp_d      = dec_err ? AXI_RESP_DECERR :
                        slv_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          arready_d   = 1'b0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          addr_d = next_addr;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_cnt_d == 2'd0) begin
          arready_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      arready_q   <= 1'b1;
      id_q        <= '0;
      addr_q      <= '0;
      wrap_mask_q <= '0;
      size_q      <= '0;
      burst_q     <= AXI_BURST_INCR;
      len_q       <= '0;
      cnt_q       <= '0;
      resp_q      <= AXI_RESP_OKAY;
      ret_q       <= 1'b0;
      ret_last_q  <= 1'b0;
      fifo_cnt_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      arready_q   <= arready_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      wrap_mask_q <= wrap_mask_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      resp_q      <= resp_d;
      ret_q       <= ret_d;
      ret_last_q  <= ret_last_d;
      fifo_cnt_q  <= fifo_cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rid     = id_q;
  assign axi.rdata   = head_q.data;
  assign axi.rresp   = head_q.resp;
  assign axi.rlast   = head_q.last;

endmodule

// File: tb/tb_axi_rd_subordinate.sv
// Bench for axi_rd_subordinate: directed and random bursts against a RAM model
// and an arithmetic reference of the burst address/response rules.
module tb_axi_rd_subordinate;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned ID_W      = 4;
  localparam int unsigned MEM_DEPTH = 1024;
  localparam int unsigned MEM_AW    = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_rd_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  axi_rd_subordinate_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_rd_subordinate #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .axi       (bus),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram [MEM_DEPTH];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [38:0]       beat_q[$];
  int                beat_cyc[$];
  logic [MEM_AW-1:0] addr_obs[$];
  logic [38:0]       exp_beats[$];
  logic [MEM_AW-1:0] exp_addrs[$];
  int first_rd, first_rv, issued, popped, max_out, e0;

  // rready pattern generator
  int rr_mode = 0;
  int rr_idx  = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  initial begin
    bus.rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0: bus.rready = 1'b1;
        1: begin bus.rready = pat[rr_idx % 6]; rr_idx++; end
        default: bus.rready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Port monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd_en) begin
        addr_obs.push_back(mem_addr);
        if (first_rd < 0) first_rd = cyc;
        issued++;
      end
      if (bus.rvalid && first_rv < 0) first_rv = cyc;
      if (bus.rvalid && bus.rready) begin
        beat_q.push_back({bus.rid, bus.rresp, bus.rlast, bus.rdata});
        beat_cyc.push_back(cyc);
        popped++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: beats and RAM word addresses from the burst rules
  function automatic void model(input logic [31:0] addr, input int len, input int size,
                                input int burst, input logic [3:0] id);
    longint bytes = longint'(1) << size;
    longint cont  = longint'(len + 1) * bytes;
    longint lower = (longint'(addr) / cont) * cont;
    longint a     = longint'(addr);
    bit legal_wrap = (len == 1) || (len == 3) || (len == 7) || (len == 15);
    logic [1:0]  resp;
    logic [31:0] data;
    int word;
    exp_beats.delete();
    exp_addrs.delete();
    if (longint'(addr) >= longint'(MEM_DEPTH * 4))          resp = 2'b11;
    else if (bytes > 4 || (burst == 2 && !legal_wrap))      resp = 2'b10;
    else                                                    resp = 2'b00;
    for (int i = 0; i <= len; i++) begin
      word = int'((a >> 2) % longint'(MEM_DEPTH));
      data = (resp == 2'b00) ? ram[word] : 32'h0;
      if (resp == 2'b00) exp_addrs.push_back(MEM_AW'(word));
      exp_beats.push_back({id, resp, 1'(i == len), data});
      if (burst == 2)      a = lower + ((a + bytes - lower) % cont);
      else if (burst != 0) a = ((a / bytes) * bytes + bytes) % (longint'(1) << 32);
    end
  endfunction

  task automatic clear_mon();
    beat_q.delete(); beat_cyc.delete(); addr_obs.delete();
    first_rd = -1; first_rv = -1; issued = 0; popped = 0; max_out = 0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst);
    int n = 0;
    while (!bus.arready && n < 200) begin @(posedge clk); #1; n++; end
    check("arready_before_ar", 64'(bus.arready), 64'd1);
    clear_mon();
    bus.arid    = id;
    bus.araddr  = addr;
    bus.arlen   = 8'(len);
    bus.arsize  = 3'(size);
    bus.arburst = 2'(burst);
    bus.arvalid = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    bus.arvalid = 1'b0;
  endtask

  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input bit chk_lat);
    int n = 0;
    send_ar(id, addr, len, size, burst);
    model(addr, len, size, burst, id);
    while ((beat_q.size() < len + 1 || !bus.arready) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    check("beat_count", 64'(beat_q.size()), 64'(len + 1));
    for (int i = 0; i < exp_beats.size() && i < beat_q.size(); i++)
      check($sformatf("beat%0d{rid,rresp,rlast,rdata}", i), 64'(beat_q[i]), 64'(exp_beats[i]));
    check("mem_read_count", 64'(addr_obs.size()), 64'(exp_addrs.size()));
    for (int i = 0; i < exp_addrs.size() && i < addr_obs.size(); i++)
      check($sformatf("mem_addr%0d", i), 64'(addr_obs[i]), 64'(exp_addrs[i]));
    check("outstanding_le_2", 64'(max_out <= 2), 64'd1);
    if (chk_lat) begin
      check("rd_en_latency", 64'(first_rd - e0), 64'd0);
      check("rvalid_latency", 64'(first_rv - e0), 64'd2);
      if (beat_cyc.size() == len + 1)
        check("back_to_back", 64'(beat_cyc[len] - beat_cyc[0]), 64'(len));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int len, size, burst;
    logic [31:0] addr;
    int legal [4] = '{1, 3, 7, 15};

    clear_mon();
    rst = 1'b1;
    bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = '0;
    bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    for (int i = 0; i < int'(MEM_DEPTH); i++) ram[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", 64'(bus.arready), 64'd1);
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("rst_rlast", 64'(bus.rlast), 64'd0);
    check("rst_rid", 64'(bus.rid), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    check("rst_rresp", 64'(bus.rresp), 64'd0);
    check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // INCR 4 beats, full rate; then WRAP
    rr_mode = 0;
    run_burst(4'd5, 32'h10, 3, 2, 1, 1'b1);
    check("incr_first_word", 64'(addr_obs.size() > 0 ? addr_obs[0] : 10'h3ff), 64'd4);
    run_burst(4'd2, 32'h18, 3, 2, 2, 1'b0);
    check("wrap_last_word", 64'(addr_obs.size() == 4 ? addr_obs[3] : 10'h3ff), 64'd5);

    // Throttled rready
    rr_idx = 0; rr_mode = 1;
    run_burst(4'd9, 32'h100, 7, 2, 1, 1'b0);

    // DECERR, FIXED, oversize SLVERR
    rr_mode = 0;
    run_burst(4'd3, 32'(MEM_DEPTH * 4), 1, 2, 1, 1'b0);
    run_burst(4'd4, 32'h8, 2, 2, 0, 1'b0);
    run_burst(4'd6, 32'h20, 0, 3, 1, 1'b0);

    // Reset during beat 2, with arvalid held across the reset
    rr_idx = 0; rr_mode = 1;
    send_ar(4'd7, 32'h200, 7, 2, 1);
    n = 0;
    while (popped < 1 && n < 200) begin @(posedge clk); #1; n++; end
    check("pre_rst_beat_seen", 64'(popped >= 1), 64'd1);
    rst = 1'b1;
    bus.arvalid = 1'b1;
    #1;
    check("midrst_rvalid", 64'(bus.rvalid), 64'd0);
    check("midrst_arready", 64'(bus.arready), 64'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_arready", 64'(bus.arready), 64'd1);
    clear_mon();
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_no_beats", 64'(beat_q.size() + addr_obs.size()), 64'd0);
    rr_mode = 0;
    run_burst(4'd8, 32'h300, 5, 2, 1, 1'b1);

    // Random bursts
    for (int k = 0; k < 24; k++) begin
      rr_mode = int'($urandom_range(0, 2));
      burst   = int'($urandom_range(0, 3));
      len     = int'($urandom_range(0, 15));
      if (burst == 2 && $urandom_range(0, 3) != 0) len = legal[$urandom_range(0, 3)];
      size    = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      addr    = ($urandom_range(0, 7) == 0) ? 32'(MEM_DEPTH * 4 + $urandom_range(0, 1000))
                                            : 32'($urandom_range(0, MEM_DEPTH * 4 - 1));
      run_burst(4'($urandom_range(0, 15)), addr, len, size, burst, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
